serdes_lane_deserializer: RTL and testbench

Multi-lane, double-buffered deserializer for the serdes path. It collects LANES words per accepted beat into an N_SAMPLES-word frame and presents the whole frame in parallel downstream. A frame may end early with recv_last, and the valid-sample count is reported with the frame. With double buffering compiled in, a new frame fills while the previous one waits for send_rdy, so streaming FFT and classifier front-ends see no idle input cycles.

---
 rtl/serdes_pkg.sv | 25 ++
 rtl/serdes_deser_bank.sv | 90 +++++++++
 rtl/serdes_lane_deserializer.sv | 151 +++++++++++++++
 tb/tb_serdes_lane_deserializer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/serdes_pkg.sv
// serdes_pkg: shared types and width helpers for the serdes lane deserializer.
//   bank_state_e : per-bank state bit (FILL = 0, FULL = 1)
//   cnt_width    : width of a sample count able to hold N_SAMPLES
//   beat_width   : width of the beat counter (minimum 1 bit)
package serdes_pkg;

    typedef enum logic {
        BANK_FILL = 1'b0,
        BANK_FULL = 1'b1
    } bank_state_e;

    // Count width: must represent N_SAMPLES itself, hence N_SAMPLES+1 values.
    function automatic int unsigned cnt_width(input int unsigned n_samples);
        return $clog2(n_samples + 1);
    endfunction

    // Beat counter width for BEATS = N_SAMPLES/LANES, never narrower than 1 bit.
    function automatic int unsigned beat_width(input int unsigned n_samples,
                                               input int unsigned lanes);
        int unsigned beats;
        beats = n_samples / lanes;
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/serdes_deser_bank.sv
// serdes_deser_bank: one frame buffer of the deserializer.
// Holds N_SAMPLES words, the valid-sample count and the FILL/FULL state bit.
//   clk, reset     : clock, asynchronous active-low reset
//   i_wr_en        : write the current beat's lanes into this bank
//   i_beat_idx     : beat index within the frame (selects word group)
//   i_wr_data      : beat payload, lane i at [i*BIT_WIDTH +: BIT_WIDTH]
//   i_close        : frame closes on this bank this cycle
//   i_close_count  : number of valid words in the closing frame
//   i_drain        : frame is consumed downstream; clear words and count
//   o_state        : FILL / FULL
//   o_words        : packed frame, word k at [k*BIT_WIDTH +: BIT_WIDTH]
//   o_count        : valid-sample count
module serdes_deser_bank
    import serdes_pkg::*;
#(
    parameter  int unsigned N_SAMPLES = 8,
    parameter  int unsigned BIT_WIDTH = 32,
    parameter  int unsigned LANES     = 1,
    localparam int unsigned CNT_W     = cnt_width(N_SAMPLES),
    localparam int unsigned BEAT_W    = beat_width(N_SAMPLES, LANES)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_wr_en,
    input  logic [BEAT_W-1:0]              i_beat_idx,
    input  logic [LANES*BIT_WIDTH-1:0]     i_wr_data,
    input  logic                           i_close,
    input  logic [CNT_W-1:0]               i_close_count,
    input  logic                           i_drain,
    output bank_state_e                    o_state,
    output logic [N_SAMPLES*BIT_WIDTH-1:0] o_words,
    output logic [CNT_W-1:0]               o_count
);

    bank_state_e                    r_state;
    bank_state_e                    w_state_nxt;
    logic [N_SAMPLES*BIT_WIDTH-1:0] r_words;
    logic [CNT_W-1:0]               r_count;

    // Bank state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= BANK_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bank next-state: FILL->FULL on close, FULL->FILL on drain
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BANK_FILL: if (i_close) w_state_nxt = BANK_FULL;
            BANK_FULL: if (i_drain) w_state_nxt = BANK_FILL;
            default:   w_state_nxt = BANK_FILL;
        endcase
    end

    // Word storage: word k belongs to beat k/LANES, lane k%LANES
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_words <= '0;
        end else if (i_drain) begin
            r_words <= '0;
        end else if (i_wr_en) begin
            for (int unsigned w = 0; w < N_SAMPLES; w++) begin
                if (i_beat_idx == BEAT_W'(w / LANES)) begin
                    r_words[w*BIT_WIDTH +: BIT_WIDTH] <=
                        i_wr_data[(w % LANES)*BIT_WIDTH +: BIT_WIDTH];
                end
            end
        end
    end

    // Valid-sample count, captured on close and cleared on drain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_drain) begin
            r_count <= '0;
        end else if (i_close) begin
            r_count <= i_close_count;
        end
    end

    assign o_state = r_state;
    assign o_words = r_words;
    assign o_count = r_count;

endmodule

// File: rtl/serdes_lane_deserializer.sv
// serdes_lane_deserializer: collects LANES words per accepted beat into an
// N_SAMPLES-word frame and presents the whole frame in parallel. Frames may
// close early on recv_last; send_count reports the valid words.
// Build option: define SERDES_DESER_DOUBLE_BUF_EN for two ping-pong banks;
// otherwise a single bank is used.
//   clk, reset  : clock, asynchronous active-low reset
//   recv_val/recv_rdy/recv_msg/recv_last : input beat handshake and payload
//   send_val/send_rdy/send_msg/send_count: output frame handshake and payload
module serdes_lane_deserializer
    import serdes_pkg::*;
#(
    parameter  int unsigned N_SAMPLES = 8,
    parameter  int unsigned BIT_WIDTH = 32,
    parameter  int unsigned LANES     = 1,
    localparam int unsigned CNT_W     = cnt_width(N_SAMPLES),
    localparam int unsigned BEAT_W    = beat_width(N_SAMPLES, LANES),
    localparam int unsigned BEATS     = N_SAMPLES / LANES
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       recv_val,
    output logic                       recv_rdy,
    input  logic [LANES*BIT_WIDTH-1:0] recv_msg,
    input  logic                       recv_last,
    output logic                       send_val,
    input  logic                       send_rdy,
    output logic [BIT_WIDTH-1:0]       send_msg [N_SAMPLES],
    output logic [CNT_W-1:0]           send_count
);

`ifdef SERDES_DESER_DOUBLE_BUF_EN
    localparam int unsigned NUM_BANKS = 2;
`else
    localparam int unsigned NUM_BANKS = 1;
`endif

    logic                           r_rst_done;
    logic [BEAT_W-1:0]              r_beat_cnt;
    logic [BEAT_W-1:0]              w_beat_cnt_nxt;
    logic                           w_accept;
    logic                           w_close;
    logic                           w_fire;
    logic [CNT_W-1:0]               w_close_count;

    logic [NUM_BANKS-1:0]           w_wr_sel;
    logic [NUM_BANKS-1:0]           w_rd_sel;
    bank_state_e                    w_state [NUM_BANKS];
    logic [N_SAMPLES*BIT_WIDTH-1:0] w_words [NUM_BANKS];
    logic [CNT_W-1:0]               w_count [NUM_BANKS];
    bank_state_e                    w_wr_state;
    bank_state_e                    w_rd_state;
    logic [N_SAMPLES*BIT_WIDTH-1:0] w_rd_words;
    logic [CNT_W-1:0]               w_rd_count;

    // Ready is held low until the first edge after reset release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
        end
    end

    assign w_accept = recv_val & recv_rdy;
    assign w_close  = w_accept & ((r_beat_cnt == BEAT_W'(BEATS - 1)) | recv_last);
    assign w_fire   = send_val & send_rdy;

    // Widened before the multiply so a full frame reports N_SAMPLES
    assign w_close_count = CNT_W'((CNT_W'(r_beat_cnt) + CNT_W'(1)) * CNT_W'(LANES));

    // Beat counter next value: restart on close, advance on other accepts
    always_comb begin
        w_beat_cnt_nxt = r_beat_cnt;
        if (w_close) begin
            w_beat_cnt_nxt = '0;
        end else if (w_accept) begin
            w_beat_cnt_nxt = r_beat_cnt + BEAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_beat_cnt <= '0;
        end else begin
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

`ifdef SERDES_DESER_DOUBLE_BUF_EN
    logic r_wr_bank;
    logic r_rd_bank;

    // Ping-pong pointers: write side advances on close, read side on fire
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
        end else begin
            if (w_close) r_wr_bank <= ~r_wr_bank;
            if (w_fire)  r_rd_bank <= ~r_rd_bank;
        end
    end

    assign w_wr_sel   = r_wr_bank ? 2'b10 : 2'b01;
    assign w_rd_sel   = r_rd_bank ? 2'b10 : 2'b01;
    assign w_wr_state = r_wr_bank ? w_state[1] : w_state[0];
    assign w_rd_state = r_rd_bank ? w_state[1] : w_state[0];
    assign w_rd_words = r_rd_bank ? w_words[1] : w_words[0];
    assign w_rd_count = r_rd_bank ? w_count[1] : w_count[0];
`else
    assign w_wr_sel   = 1'b1;
    assign w_rd_sel   = 1'b1;
    assign w_wr_state = w_state[0];
    assign w_rd_state = w_state[0];
    assign w_rd_words = w_words[0];
    assign w_rd_count = w_count[0];
`endif

    // Frame banks
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        serdes_deser_bank #(
            .N_SAMPLES (N_SAMPLES),
            .BIT_WIDTH (BIT_WIDTH),
            .LANES     (LANES)
        ) u_bank (
            .clk           (clk),
            .reset         (reset),
            .i_wr_en       (w_accept & w_wr_sel[b]),
            .i_beat_idx    (r_beat_cnt),
            .i_wr_data     (recv_msg),
            .i_close       (w_close & w_wr_sel[b]),
            .i_close_count (w_close_count),
            .i_drain       (w_fire & w_rd_sel[b]),
            .o_state       (w_state[b]),
            .o_words       (w_words[b]),
            .o_count       (w_count[b])
        );
    end

    assign recv_rdy   = r_rst_done & (w_wr_state == BANK_FILL);
    assign send_val   = (w_rd_state == BANK_FULL);
    assign send_count = w_rd_count;

    // Unpack the read bank onto the parallel frame output
    always_comb begin
        for (int unsigned i = 0; i < N_SAMPLES; i++) begin
            send_msg[i] = w_rd_words[i*BIT_WIDTH +: BIT_WIDTH];
        end
    end

endmodule

// File: tb/tb_serdes_lane_deserializer.sv
// Bench for serdes_lane_deserializer: scoreboard of expected frames built
// from accepted beats, checked by a negedge monitor. A second small instance
// (N_SAMPLES=4, LANES=1) covers single-word frames.
module tb_serdes_lane_deserializer;

`ifdef SERDES_DESER_DOUBLE_BUF_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    localparam int N  = 8;
    localparam int L  = 2;
    localparam int BW = 32;

    typedef struct {
        logic [BW-1:0] w [N];
        int            cnt;
    } frame_t;

    logic          clk;
    logic          reset;
    logic          recv_val;
    logic          recv_rdy;
    logic [L*BW-1:0] recv_msg;
    logic          recv_last;
    logic          send_val;
    logic          send_rdy;
    logic [BW-1:0] send_msg [N];
    logic [3:0]    send_count;

    logic          v1, rdy1, last1, sval1, srdy1;
    logic [BW-1:0] msg1;
    logic [BW-1:0] smsg1 [4];
    logic [2:0]    scnt1;

    int n_checks = 0;
    int n_fail   = 0;

    serdes_lane_deserializer #(.N_SAMPLES(N), .BIT_WIDTH(BW), .LANES(L)) u_dut (
        .clk(clk), .reset(reset),
        .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_msg(recv_msg), .recv_last(recv_last),
        .send_val(send_val), .send_rdy(send_rdy), .send_msg(send_msg), .send_count(send_count)
    );

    serdes_lane_deserializer #(.N_SAMPLES(4), .BIT_WIDTH(BW), .LANES(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .recv_val(v1), .recv_rdy(rdy1), .recv_msg(msg1), .recv_last(last1),
        .send_val(sval1), .send_rdy(srdy1), .send_msg(smsg1), .send_count(scnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frames outstanding, partial frame, expected frame queue
    int      m_out  = 0;
    bit      m_live = 0;
    int      m_fill = 0;
    logic [BW-1:0] m_buf [N];
    frame_t  m_exp [$];

    always @(negedge clk) begin
        bit     exp_rdy;
        bit     exp_val;
        frame_t f;
        if (!reset) begin
            chk("rst_recv_rdy", recv_rdy, 0);
            chk("rst_send_val", send_val, 0);
            chk("rst_send_count", send_count, 0);
            for (int i = 0; i < N; i++) chk("rst_send_msg", send_msg[i], 0);
            m_live = 0;
            m_out  = 0;
            m_fill = 0;
            m_exp.delete();
        end else begin
            exp_rdy = m_live && (m_out < NB);
            exp_val = (m_out > 0);
            chk("recv_rdy", recv_rdy, exp_rdy);
            chk("send_val", send_val, exp_val);
            if (exp_val && send_rdy) begin
                f = m_exp.pop_front();
                chk("send_count", send_count, f.cnt);
                for (int i = 0; i < N; i++) chk("send_msg", send_msg[i], f.w[i]);
                m_out--;
            end
            if (exp_rdy && recv_val) begin
                for (int l = 0; l < L; l++) begin
                    m_buf[m_fill] = recv_msg[l*BW +: BW];
                    m_fill++;
                end
                if (m_fill == N || recv_last) begin
                    for (int i = 0; i < N; i++) f.w[i] = (i < m_fill) ? m_buf[i] : '0;
                    f.cnt = m_fill;
                    m_exp.push_back(f);
                    m_out++;
                    m_fill = 0;
                end
            end
            m_live = 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted; returns at posedge+1
    task automatic drive_beat(input logic [BW-1:0] l0, input logic [BW-1:0] l1, input logic last);
        int n;
        n = 0;
        recv_val  = 1'b1;
        recv_msg  = {l1, l0};
        recv_last = last;
        while (!recv_rdy && n < 50) begin
            step();
            n++;
        end
        if (!recv_rdy) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_accept_timeout: got rdy=0 expected rdy=1 within 50 cycles");
        end
        step();
    endtask

    task automatic idle(input int cycles);
        recv_val  = 1'b0;
        recv_last = 1'b0;
        repeat (cycles) step();
    endtask

    initial begin
        reset = 1'b0; recv_val = 1'b0; recv_msg = '0; recv_last = 1'b0; send_rdy = 1'b0;
        v1 = 1'b0; msg1 = '0; last1 = 1'b0; srdy1 = 1'b1;
        repeat (3) step();
        reset = 1'b1;
        idle(2);

        // Full frame 0..7
        send_rdy = 1'b1;
        for (int b = 0; b < 4; b++) drive_beat(BW'(2*b), BW'(2*b+1), 1'b0);
        idle(3);

        // Short frame closed by recv_last, then a full frame from index 0
        drive_beat(0, 1, 1'b0);
        drive_beat(2, 3, 1'b1);
        for (int b = 0; b < 4; b++) drive_beat(BW'(20+2*b), BW'(21+2*b), 1'b0);
        idle(3);

        // Back-pressure: stream with send_rdy low, then drain
        send_rdy = 1'b0;
        recv_val = 1'b1;
        for (int c = 0; c < 12; c++) begin
            recv_msg = {BW'($urandom), BW'($urandom)};
            step();
        end
        recv_val = 1'b0;
        idle(2);
        send_rdy = 1'b1;
        idle(4);

        // Continuous streaming with send_rdy high
        recv_val = 1'b1;
        for (int c = 0; c < 40; c++) begin
            recv_msg = {BW'($urandom), BW'($urandom)};
            step();
        end
        idle(3);

        // Reset mid-frame, then a clean frame 10..17
        for (int b = 0; b < 3; b++) drive_beat(BW'(100+b), BW'(200+b), 1'b0);
        reset    = 1'b0;
        recv_val = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        for (int b = 0; b < 4; b++) drive_beat(BW'(10+2*b), BW'(11+2*b), 1'b0);
        idle(3);

        // Random traffic
        for (int c = 0; c < 300; c++) begin
            recv_val  = ($urandom_range(0, 3) != 0);
            recv_last = ($urandom_range(0, 4) == 0);
            recv_msg  = {BW'($urandom), BW'($urandom)};
            send_rdy  = ($urandom_range(0, 2) != 0);
            step();
        end
        send_rdy = 1'b1;
        idle(10);
        chk("drain_queue_empty", m_exp.size(), 0);
        chk("drain_send_val", send_val, 0);

        // Single-word frames on the LANES=1 instance
        for (int k = 1; k <= 4; k++) begin
            int n;
            n     = 0;
            v1    = 1'b1;
            msg1  = BW'(k * 5);
            last1 = 1'b1;
            while (!rdy1 && n < 20) begin
                step();
                n++;
            end
            chk("l1_rdy", rdy1, 1);
            step();
            v1    = 1'b0;
            last1 = 1'b0;
            @(negedge clk);
            chk("l1_send_val", sval1, 1);
            chk("l1_send_count", scnt1, 1);
            chk("l1_word0", smsg1[0], BW'(k * 5));
            chk("l1_word1", smsg1[1], 0);
            chk("l1_word2", smsg1[2], 0);
            chk("l1_word3", smsg1[3], 0);
            step();
        end
        @(negedge clk);
        chk("l1_drained", sval1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
